decoder_sweep: RTL and testbench
================================

Name: decoder_sweep

Overview:
Parametrised, registered N-to-2^N one-hot decoder. Next generation of the register-file write-select decoder. Adds a one-cycle output register and a built-in sweep sequencer. The sweep asserts every output line in turn, one per step, so the register file can be cleared or initialised without an external address counter. It sits between the register-file control logic and the per-register write enables.

Parameters:
SEL_W, 3, select width; number of output lines OUT_W = 2^SEL_W (derived, not overridable)
SWEEP_GAP, 0, number of all-zero cycles inserted between consecutive sweep steps (0..15)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
usr_input  input  SEL_W  line select in normal mode
ENABLE  input  1  normal-mode decode enable
sweep_start  input  1  single-cycle request to start a sweep; honoured only in IDLE
Dout  output  OUT_W  registered one-hot (or all-zero) decode output
sweep_busy  output  1  high while a sweep is in progress
sweep_done  output  1  one-cycle pulse when a sweep completes

Behaviour:
- Clocking: one clock, clk. Reset rst is asynchronous and active-high. All outputs are registered.
- Reset values: Dout=0, sweep_busy=0, sweep_done=0, state=IDLE, sweep index=0, gap counter=0.
- Invariant: popcount(Dout) <= 1 in every cycle.
- States:
  - IDLE: normal decode.
  - STEP: one sweep line asserted.
  - GAP: zero cycles between sweep steps.
- IDLE, normal decode, latency 1 cycle:
  - At each edge, Dout <= ENABLE ? (1 << usr_input) : 0.
  - usr_input is don't-care when ENABLE=0.
  - sweep_done <= 0.
- IDLE with sweep_start=1 at an edge:
  - Next state STEP, index=0, Dout <= 1<<0, sweep_busy <= 1.
  - sweep_start has priority over ENABLE; ENABLE and usr_input are ignored in that cycle.
- STEP, at each edge:
  - If index == OUT_W-1: next state IDLE, Dout <= 0, sweep_busy <= 0, sweep_done <= 1 for exactly one cycle.
  - Else if SWEEP_GAP == 0: index++, stay in STEP, Dout <= 1<<index.
  - Else: next state GAP, Dout <= 0, gap counter = 1.
- GAP, at each edge:
  - If gap counter == SWEEP_GAP: index++, next state STEP, Dout <= 1<<index.
  - Else gap counter++, Dout stays 0.
- During STEP and GAP:
  - sweep_busy = 1.
  - ENABLE, usr_input and sweep_start are ignored; a re-request is dropped, not queued.
- Sweep duration: sweep_busy is high for OUT_W + (OUT_W-1)*SWEEP_GAP cycles. No gap is inserted after the last line. sweep_done follows in the first IDLE cycle.
- Back-to-back: sweep_start asserted in the same cycle sweep_done is high is honoured, because the state is IDLE. Dout then goes from 0 to line 0 on the next edge.
- Reset mid-sweep: immediate abort, all outputs 0, and no sweep_done pulse.
- Sweep index and gap counter are SEL_W and 4 bits wide. The index never wraps; termination is the compare with OUT_W-1.

Test Plan:
- Normal decode, SEL_W=3: ENABLE=1, usr_input=5 at edge k -> Dout=8'b0010_0000 from edge k. ENABLE=0 at edge k+1 -> Dout=0. Step usr_input 0..7 -> each value appears exactly 1 cycle later.
- Sweep, SWEEP_GAP=0: sweep_start pulse -> Dout shows 01,02,04,...,80 on 8 consecutive cycles with sweep_busy=1. Next cycle: Dout=0, sweep_busy=0, sweep_done=1 for 1 cycle.
- Sweep, SWEEP_GAP=2: sweep_start pulse -> pattern 01,0,0,02,0,0,...,80 with sweep_busy high for 22 cycles, then sweep_done pulse. popcount(Dout) <= 1 checked in every cycle.
- Priority and ignore: sweep_start=1 with ENABLE=1, usr_input=6 -> first output 8'h01, not 8'h40. ENABLE toggling and extra sweep_start pulses mid-sweep -> sequence unchanged, and only one sweep_done.
- Reset mid-sweep: assert rst asynchronously at line 3, between clock edges -> Dout=0 and sweep_busy=0 immediately. No sweep_done pulse. After release, ENABLE=1, usr_input=2 -> Dout=8'h04 one cycle later.
- Back-to-back sweep: sweep_start asserted in the sweep_done cycle -> second sweep starts at 8'h01 on the next edge, after exactly one Dout=0 cycle between the two sweeps.

Source files
------------

// File: rtl/decoder_sweep.sv
// decoder_sweep: registered one-hot decoder with a built-in sweep sequencer that walks every output line
module decoder_sweep #(
  parameter int SEL_W     = 3,
  parameter int SWEEP_GAP = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEL_W-1:0]      usr_input,
  input  logic                  ENABLE,
  input  logic                  sweep_start,
  output logic [(1<<SEL_W)-1:0] Dout,
  output logic                  sweep_busy,
  output logic                  sweep_done
);
  localparam int OUT_W = 1 << SEL_W;
  typedef enum logic [1:0] {IDLE, STEP, GAP} state_t;
  state_t           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [3:0]       gap_q, gap_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic             busy_q, busy_d, done_q, done_d;
  // next state and registered outputs; sweep_start outranks normal decode in IDLE
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    dout_d  = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sweep_start) begin
          state_d = STEP;
          idx_d   = '0;
          dout_d  = OUT_W'(1);
          busy_d  = 1'b1;
        end else begin
          dout_d = ENABLE ? OUT_W'(1) << usr_input : '0;
        end
      end
      STEP: begin
        if (idx_q == SEL_W'(OUT_W - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else if (SWEEP_GAP == 0) begin
          idx_d  = idx_q + 1'b1;
          dout_d = OUT_W'(1) << idx_d;
          busy_d = 1'b1;
        end else begin
          state_d = GAP;
          gap_d   = 4'd1;
          busy_d  = 1'b1;
        end
      end
      GAP: begin
        busy_d = 1'b1;
        if (gap_q == 4'(SWEEP_GAP)) begin
          state_d = STEP;
          idx_d   = idx_q + 1'b1;
          gap_d   = '0;
          dout_d  = OUT_W'(1) << idx_d;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset aborts any sweep without a done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign Dout       = dout_q;
  assign sweep_busy = busy_q;
  assign sweep_done = done_q;
endmodule

// File: tb/tb_decoder_sweep.sv
// tb_decoder_sweep: random and directed checks of two decoder_sweep instances (gap 0 and gap 2) against a sweep-age model
module tb_decoder_sweep;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] usr_input = '0;
  logic       en = 1'b0;
  logic       sweep_start = 1'b0;
  logic [7:0] d [2];
  logic       b [2];
  logic       dn [2];
  int         n_checks = 0;
  int         n_fail = 0;
  int         age [2] = '{-1, -1};
  int         gaps [2] = '{0, 2};
  logic [7:0] e_d [2];
  logic       e_b [2];
  logic       e_dn [2];
  int         dones [2];
  decoder_sweep #(.SEL_W(3), .SWEEP_GAP(0)) dut0 (
    .clk(clk), .rst(rst), .usr_input(usr_input), .ENABLE(en), .sweep_start(sweep_start),
    .Dout(d[0]), .sweep_busy(b[0]), .sweep_done(dn[0])
  );
  decoder_sweep #(.SEL_W(3), .SWEEP_GAP(2)) dut2 (
    .clk(clk), .rst(rst), .usr_input(usr_input), .ENABLE(en), .sweep_start(sweep_start),
    .Dout(d[1]), .sweep_busy(b[1]), .sweep_done(dn[1])
  );
  always #5 clk = ~clk;
  // age = cycles since the current sweep's first line; sweep lasts L = 8 + 7*gap cycles, done shows at age L
  function automatic void model_edge(input bit st, input bit e, input logic [2:0] sel);
    for (int k = 0; k < 2; k++) begin
      int l = 8 + 7 * gaps[k];
      if (age[k] >= 0 && age[k] < l) age[k]++;
      else if (st) age[k] = 0;
      else age[k] = -1;
      if (age[k] < 0) begin
        e_d[k] = e ? 8'(1 << sel) : 8'h00; e_b[k] = 1'b0; e_dn[k] = 1'b0;
      end else if (age[k] == l) begin
        e_d[k] = 8'h00; e_b[k] = 1'b0; e_dn[k] = 1'b1;
      end else begin
        e_d[k] = (age[k] % (gaps[k] + 1) == 0) ? 8'(1 << (age[k] / (gaps[k] + 1))) : 8'h00;
        e_b[k] = 1'b1; e_dn[k] = 1'b0;
      end
    end
  endfunction
  task automatic cycle(input bit st, input bit e, input logic [2:0] sel);
    sweep_start = st; en = e; usr_input = sel;
    @(posedge clk); #1;
    model_edge(st, e, sel);
  endtask
  task automatic test_reset();
    #12;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (d[k] !== 8'h00) begin n_fail++; $display("FAIL reset dout dut%0d got %h want 00", k, d[k]); end
      n_checks++; if (b[k] !== 1'b0) begin n_fail++; $display("FAIL reset busy dut%0d got %b want 0", k, b[k]); end
      n_checks++; if (dn[k] !== 1'b0) begin n_fail++; $display("FAIL reset done dut%0d got %b want 0", k, dn[k]); end
    end
    @(negedge clk); rst = 1'b0;
  endtask
  task automatic test_decode();
    cycle(0, 1, 5);
    n_checks++; if (d[0] !== 8'b0010_0000) begin n_fail++; $display("FAIL decode5 got %h want 20", d[0]); end
    for (int i = 0; i < 50; i++) begin
      if (i == 0) cycle(0, 0, 5);
      else if (i <= 8) cycle(0, 1, 3'(i - 1));
      else cycle(0, 1'($urandom_range(0, 1)), 3'($urandom));
      for (int k = 0; k < 2; k++) begin
        n_checks++; if (d[k] !== e_d[k]) begin n_fail++; $display("FAIL decode dut%0d step %0d dout got %h want %h", k, i, d[k], e_d[k]); end
        n_checks++; if (b[k] !== 1'b0 || dn[k] !== 1'b0) begin n_fail++; $display("FAIL decode flags dut%0d busy %b done %b want 0 0", k, b[k], dn[k]); end
      end
    end
  endtask
  task automatic test_sweep();
    dones = '{0, 0};
    for (int t = 0; t < 26; t++) begin
      cycle(t == 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
        dones[k] += int'(dn[k] === 1'b1);
        n_checks++; if (d[k] !== e_d[k]) begin n_fail++; $display("FAIL sweep dut%0d t%0d dout got %h want %h", k, t, d[k], e_d[k]); end
        n_checks++; if (b[k] !== e_b[k]) begin n_fail++; $display("FAIL sweep dut%0d t%0d busy got %b want %b", k, t, b[k], e_b[k]); end
        n_checks++; if (dn[k] !== e_dn[k]) begin n_fail++; $display("FAIL sweep dut%0d t%0d done got %b want %b", k, t, dn[k], e_dn[k]); end
        n_checks++; if ($countones(d[k]) > 1) begin n_fail++; $display("FAIL sweep onehot dut%0d t%0d got %h want popcount<=1", k, t, d[k]); end
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (dones[k] != 1) begin n_fail++; $display("FAIL sweep done count dut%0d got %0d want 1", k, dones[k]); end
    end
  endtask
  task automatic test_priority_ignore();
    dones = '{0, 0};
    for (int t = 0; t < 26; t++) begin
      if (t == 0) cycle(1, 1, 6);
      else if (t <= 8) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom));
      else cycle(0, 0, 0);
      for (int k = 0; k < 2; k++) begin
        dones[k] += int'(dn[k] === 1'b1);
        n_checks++; if (d[k] !== e_d[k]) begin n_fail++; $display("FAIL prio dut%0d t%0d dout got %h want %h", k, t, d[k], e_d[k]); end
        n_checks++; if (b[k] !== e_b[k] || dn[k] !== e_dn[k]) begin n_fail++; $display("FAIL prio dut%0d t%0d busy/done got %b%b want %b%b", k, t, b[k], dn[k], e_b[k], e_dn[k]); end
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (dones[k] != 1) begin n_fail++; $display("FAIL prio done count dut%0d got %0d want 1", k, dones[k]); end
    end
  endtask
  task automatic test_reset_mid();
    bit saw_done = 1'b0;
    for (int t = 0; t < 4; t++) cycle(t == 0, 0, 0);
    n_checks++; if (d[0] !== 8'h08) begin n_fail++; $display("FAIL midrst line3 got %h want 08", d[0]); end
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (d[k] !== 8'h00 || b[k] !== 1'b0) begin n_fail++; $display("FAIL midrst async dut%0d dout %h busy %b want 00 0", k, d[k], b[k]); end
    end
    age = '{-1, -1};
    repeat (2) begin
      @(posedge clk); #1;
      saw_done |= (dn[0] === 1'b1) | (dn[1] === 1'b1);
    end
    @(negedge clk); rst = 1'b0;
    cycle(0, 1, 2);
    saw_done |= (dn[0] === 1'b1) | (dn[1] === 1'b1);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (d[k] !== 8'h04) begin n_fail++; $display("FAIL midrst decode dut%0d got %h want 04", k, d[k]); end
    end
    n_checks++; if (saw_done) begin n_fail++; $display("FAIL midrst done pulse got 1 want 0"); end
    cycle(0, 0, 0);
  endtask
  task automatic test_back_to_back();
    for (int t = 0; t < 50; t++) begin
      cycle(t == 0 || t == 9 || t == 23, 0, 0);
      if (t == 9) begin
        n_checks++; if (d[0] !== 8'h01) begin n_fail++; $display("FAIL b2b restart got %h want 01", d[0]); end
      end
      for (int k = 0; k < 2; k++) begin
        n_checks++; if (d[k] !== e_d[k]) begin n_fail++; $display("FAIL b2b dut%0d t%0d dout got %h want %h", k, t, d[k], e_d[k]); end
        n_checks++; if (b[k] !== e_b[k] || dn[k] !== e_dn[k]) begin n_fail++; $display("FAIL b2b dut%0d t%0d busy/done got %b%b want %b%b", k, t, b[k], dn[k], e_b[k], e_dn[k]); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_decode();
    test_sweep();
    test_priority_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
